// File: rtl/ecc_apb_master.sv
// APB initiator for the ECC block: writes DATA_IN, CODEWORD_WIDTH, NOISE, then CTRL, waits for done, holds response.
// Define ECC_APB_READBACK_EN to read back the three operand registers before the CTRL write.
module ecc_apb_master #(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter logic [AMBA_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_ctrl,
  input  logic [1:0]                 cmd_width,
  input  logic [DATA_WIDTH-1:0]      cmd_data,
  input  logic [DATA_WIDTH-1:0]      cmd_noise,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [1:0]                 rsp_nerr,
  output logic [1:0]                 rsp_status
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_WAIT, S_RESP} state_t;

`ifdef ECC_APB_READBACK_EN
  localparam int NXFER = 7;
`else
  localparam int NXFER = 4;
`endif
  localparam int CTRL_IDX = NXFER - 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                state_q;
  logic [2:0]            idx_q;
  logic [CW-1:0]         cnt_q;
  logic [1:0]            ctrl_q, width_q;
  logic [DATA_WIDTH-1:0] data_q, noise_q;

  // Transfer table: writes 0..2, optional reads 3..5, CTRL always at CTRL_IDX.
  function automatic logic [AMBA_ADDR_WIDTH-1:0] xfer_addr(input logic [2:0] idx);
    logic [AMBA_ADDR_WIDTH-1:0] off;
    if (idx == 3'(CTRL_IDX)) off = '0;
    else begin
      case (idx)
        3'd0, 3'd3: off = AMBA_ADDR_WIDTH'(4);
        3'd1, 3'd4: off = AMBA_ADDR_WIDTH'(8);
        default:    off = AMBA_ADDR_WIDTH'(12);
      endcase
    end
    return BASE_ADDR + off;
  endfunction

  function automatic logic [AMBA_WORD-1:0] xfer_word(input logic [2:0] idx, input logic [1:0] c,
                                                      input logic [1:0] w, input logic [DATA_WIDTH-1:0] d,
                                                      input logic [DATA_WIDTH-1:0] n);
    logic [AMBA_WORD-1:0] v;
    if (idx == 3'(CTRL_IDX)) v = AMBA_WORD'(c);
    else begin
      case (idx)
        3'd0, 3'd3: v = AMBA_WORD'(d);
        3'd1, 3'd4: v = AMBA_WORD'(w);
        default:    v = AMBA_WORD'(n);
      endcase
    end
    return v;
  endfunction

  // Next transfer's fields; on accept the operands come straight from the command port.
  logic [2:0]            nidx;
  logic                  n_write;
  logic [AMBA_WORD-1:0]  n_word;
  logic [AMBA_ADDR_WIDTH-1:0] n_addr;

  always_comb begin
    nidx    = (state_q == S_IDLE) ? 3'd0 : idx_q + 3'd1;
    n_write = (nidx < 3'd3) || (nidx == 3'(CTRL_IDX));
    n_addr  = xfer_addr(nidx);
    if (state_q == S_IDLE) n_word = xfer_word(nidx, cmd_ctrl, cmd_width, cmd_data, cmd_noise);
    else                   n_word = xfer_word(nidx, ctrl_q, width_q, data_q, noise_q);
  end

`ifdef ECC_APB_READBACK_EN
  logic mism_q;
  logic rd_mism;
  assign rd_mism = !PWRITE && (PRDATA != xfer_word(idx_q, ctrl_q, width_q, data_q, noise_q));
`else
  logic unused_prdata;
  assign unused_prdata = ^PRDATA;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      ctrl_q     <= '0;
      width_q    <= '0;
      data_q     <= '0;
      noise_q    <= '0;
      cmd_ready  <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_nerr   <= '0;
      rsp_status <= '0;
`ifdef ECC_APB_READBACK_EN
      mism_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            ctrl_q    <= cmd_ctrl;
            width_q   <= cmd_width;
            data_q    <= cmd_data;
            noise_q   <= cmd_noise;
            idx_q     <= 3'd0;
            cmd_ready <= 1'b0;
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            PWRITE    <= n_write;
            PADDR     <= n_addr;
            PWDATA    <= n_write ? n_word : '0;
`ifdef ECC_APB_READBACK_EN
            mism_q    <= 1'b0;
`endif
            state_q   <= S_SETUP;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
          state_q <= S_ACCESS;
        end
        S_ACCESS: begin
`ifdef ECC_APB_READBACK_EN
          mism_q <= mism_q | rd_mism;
`endif
          if (idx_q == 3'(CTRL_IDX)) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            cnt_q   <= CW'(1);
            state_q <= S_WAIT;
`ifdef ECC_APB_READBACK_EN
          end else if (idx_q == 3'(CTRL_IDX - 1) && (mism_q || rd_mism)) begin
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_data   <= '0;
            rsp_nerr   <= '0;
            rsp_status <= 2'b10;
            state_q    <= S_RESP;
`endif
          end else begin
            idx_q   <= nidx;
            PENABLE <= 1'b0;
            PWRITE  <= n_write;
            PADDR   <= n_addr;
            PWDATA  <= n_write ? n_word : '0;
            state_q <= S_SETUP;
          end
        end
        S_WAIT: begin
          if (operation_done) begin
            rsp_valid  <= 1'b1;
            rsp_data   <= data_out;
            rsp_nerr   <= num_of_errors;
            rsp_status <= 2'b00;
            state_q    <= S_RESP;
          end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            // Response lands exactly TIMEOUT_CYCLES after the CTRL access cycle.
            rsp_valid  <= 1'b1;
            rsp_data   <= '0;
            rsp_nerr   <= '0;
            rsp_status <= 2'b01;
            state_q    <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_apb_master.sv
// Directed bench for ecc_apb_master with a simple zero-wait APB register slave.
module tb_ecc_apb_master;
`ifdef ECC_APB_READBACK_EN
  localparam int NX = 7;
`else
  localparam int NX = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_ctrl, cmd_width;
  logic [31:0] cmd_data, cmd_noise;
  logic [19:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic        operation_done;
  logic [31:0] data_out;
  logic [1:0]  num_of_errors;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_nerr, rsp_status;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs [4] = '{default: 32'h0};
  int          ctrl_writes = 0;
  logic        corrupt = 1'b0;

  always #5 clk = ~clk;

  ecc_apb_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ctrl(cmd_ctrl), .cmd_width(cmd_width),
    .cmd_data(cmd_data), .cmd_noise(cmd_noise),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PRDATA(PRDATA),
    .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_nerr(rsp_nerr),
    .rsp_status(rsp_status)
  );

  always @(posedge clk) begin
    if (PSEL && PENABLE && PWRITE) begin
      regs[PADDR[3:2]] <= PWDATA;
      if (PADDR[3:2] == 2'd0) ctrl_writes <= ctrl_writes + 1;
    end
  end
  assign PRDATA = (corrupt && PADDR[3:2] == 2'd2) ? 32'h1 : regs[PADDR[3:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] c, input logic [1:0] w, input logic [31:0] d, input logic [31:0] n);
    int k;
    @(negedge clk);
    cmd_ctrl = c; cmd_width = w; cmd_data = d; cmd_noise = n; cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    chk("cmd_ready_seen", {31'b0, cmd_ready}, 32'h1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_ctrl(output int n);
    n = 0;
    while (!(PSEL && PENABLE && PADDR == 20'h0) && n < 60) begin @(negedge clk); n++; end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
  endtask

  logic [31:0] ea [7];
  logic [31:0] ed [7];
  logic        ew [7];
  int n, m, cw0;

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_ctrl = '0; cmd_width = '0; cmd_data = '0; cmd_noise = '0;
    operation_done = 1'b0; data_out = '0; num_of_errors = '0; rsp_ready = 1'b1;
`ifdef ECC_APB_READBACK_EN
    ea = '{32'h4, 32'h8, 32'hC, 32'h4, 32'h8, 32'hC, 32'h0};
    ew = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    ea = '{32'h4, 32'h8, 32'hC, 32'h0, 32'h0, 32'h0, 32'h0};
    ew = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
    ed = '{32'h0A, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    // Reset state
    #12;
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'h0);
    chk("rst_psel", {31'b0, PSEL}, 32'h0);
    chk("rst_penable", {31'b0, PENABLE}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_paddr", {12'b0, PADDR}, 32'h0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);

    // Encode: cycle-by-cycle APB sequence
    send_cmd(2'b00, 2'b00, 32'h0A, 32'h0);
    for (int k = 0; k < 2 * NX; k++) begin
      @(negedge clk);
      chk("enc_psel", {31'b0, PSEL}, 32'h1);
      chk("enc_penable", {31'b0, PENABLE}, k % 2);
      chk("enc_paddr", {12'b0, PADDR}, ea[k / 2]);
      chk("enc_pwrite", {31'b0, PWRITE}, {31'b0, ew[k / 2]});
      chk("enc_pwdata", PWDATA, ed[k / 2]);
      chk("enc_cmd_ready", {31'b0, cmd_ready}, 32'h0);
    end
    @(negedge clk);
    chk("enc_wait_psel", {31'b0, PSEL}, 32'h0);
    operation_done = 1'b1; data_out = 32'h5A; num_of_errors = 2'd0;
    @(negedge clk);
    operation_done = 1'b0;
    chk("enc_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("enc_rsp_data", rsp_data, 32'h5A);
    chk("enc_rsp_status", {30'b0, rsp_status}, 32'h0);
    @(negedge clk);
    chk("enc_rsp_drop", {31'b0, rsp_valid}, 32'h0);
    chk("enc_cmd_ready_back", {31'b0, cmd_ready}, 32'h1);

    // Full channel with response backpressure and a stray done pulse
    rsp_ready = 1'b0;
    send_cmd(2'b10, 2'b10, 32'hDEADBEEF, 32'h4);
    wait_ctrl(n);
    @(negedge clk);
    chk("fc_reg_data", regs[1], 32'hDEADBEEF);
    chk("fc_reg_width", regs[2], 32'h2);
    chk("fc_reg_noise", regs[3], 32'h4);
    chk("fc_reg_ctrl", regs[0], 32'h2);
    operation_done = 1'b1; data_out = 32'hDEADBEEF; num_of_errors = 2'd1;
    @(negedge clk);
    operation_done = 1'b0;
    chk("fc_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("fc_rsp_data", rsp_data, 32'hDEADBEEF);
    chk("fc_rsp_nerr", {30'b0, rsp_nerr}, 32'h1);
    chk("fc_rsp_status", {30'b0, rsp_status}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) begin operation_done = 1'b1; data_out = 32'h11111111; num_of_errors = 2'd3; end
      if (i == 5) operation_done = 1'b0;
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'h1);
      chk("bp_rsp_data", rsp_data, 32'hDEADBEEF);
      chk("bp_rsp_nerr", {30'b0, rsp_nerr}, 32'h1);
      chk("bp_cmd_ready", {31'b0, cmd_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rsp_consumed", {31'b0, rsp_valid}, 32'h0);

    // Timeout: no done, response exactly 64 cycles after CTRL access
    send_cmd(2'b01, 2'b01, 32'h1234, 32'h0);
    wait_ctrl(n);
    chk("to_ctrl_latency", n, 2 * NX);
    wait_rsp(m);
    chk("to_rsp_latency", m, 64);
    chk("to_status", {30'b0, rsp_status}, 32'h1);
    chk("to_rsp_data", rsp_data, 32'h0);
    chk("to_rsp_nerr", {30'b0, rsp_nerr}, 32'h0);
    @(negedge clk);

    // Reset during NOISE setup
    cw0 = ctrl_writes;
    send_cmd(2'b00, 2'b00, 32'h55, 32'h3);
    n = 0;
    while (!(PSEL && !PENABLE && PADDR == 20'hC) && n < 20) begin @(negedge clk); n++; end
    chk("mr_found_noise_setup", {12'b0, PADDR}, 32'hC);
    rst = 1'b0;
    #1;
    chk("mr_psel_async", {31'b0, PSEL}, 32'h0);
    chk("mr_penable_async", {31'b0, PENABLE}, 32'h0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("mr_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    chk("mr_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("mr_no_ctrl_write", ctrl_writes, cw0);

    // Decode: done during the register phase is ignored
    send_cmd(2'b01, 2'b01, 32'hABCD, 32'h10);
    operation_done = 1'b1; data_out = 32'h0BAD;
    @(negedge clk);
    operation_done = 1'b0;
    wait_ctrl(n);
    @(negedge clk);
    chk("dec_no_early_rsp", {31'b0, rsp_valid}, 32'h0);
    operation_done = 1'b1; data_out = 32'hABCD; num_of_errors = 2'd2;
    @(negedge clk);
    operation_done = 1'b0;
    chk("dec_rsp_data", rsp_data, 32'hABCD);
    chk("dec_rsp_nerr", {30'b0, rsp_nerr}, 32'h2);
    @(negedge clk);

`ifdef ECC_APB_READBACK_EN
    // Readback mismatch on CODEWORD_WIDTH skips the CTRL write
    cw0 = ctrl_writes;
    corrupt = 1'b1;
    send_cmd(2'b00, 2'b10, 32'h33, 32'h1);
    wait_rsp(m);
    chk("rb_status", {30'b0, rsp_status}, 32'h2);
    chk("rb_rsp_data", rsp_data, 32'h0);
    chk("rb_no_ctrl_write", ctrl_writes, cw0);
    corrupt = 1'b0;
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
